spc7110_dataport: RTL

SPC7110_DATAPORT -- requirements
Module: spc7110_dataport

---
 rtl/spc7110_pkg.sv | 45 ++++
 rtl/spc7110_romfetch.sv | 88 ++++++++
 rtl/spc7110_dataport.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/spc7110_pkg.sv
// Shared definitions for the SPC7110 data port: register offsets, MODE bits,
// fetch FSM encoding, bank-select reset values and the 16->24 bit extender.
package spc7110_pkg;

   // Direct window ($481x) offsets
   localparam logic [3:0] DIR_DATA   = 4'h0;
   localparam logic [3:0] DIR_DP0    = 4'h1;
   localparam logic [3:0] DIR_DP1    = 4'h2;
   localparam logic [3:0] DIR_DP2    = 4'h3;
   localparam logic [3:0] DIR_ADJ0   = 4'h4;
   localparam logic [3:0] DIR_ADJ1   = 4'h5;
   localparam logic [3:0] DIR_STP0   = 4'h6;
   localparam logic [3:0] DIR_STP1   = 4'h7;
   localparam logic [3:0] DIR_MODE   = 4'h8;
   localparam logic [3:0] DIR_STATUS = 4'hB;

   // Banked window ($483x) offsets
   localparam logic [3:0] BANK_SRAM  = 4'h0;
   localparam logic [3:0] BANK_D     = 4'h1;
   localparam logic [3:0] BANK_E     = 4'h2;
   localparam logic [3:0] BANK_F     = 4'h3;

   // MODE bit positions
   localparam int MODE_STEP_EN     = 0;  // 0: DP+=1, 1: DP+=STP
   localparam int MODE_STEP_SIGNED = 1;  // sign-extend STP
   localparam int MODE_ADJ_EN      = 2;  // add ADJ to the fetch address
   localparam int MODE_ADJ_SIGNED  = 3;  // sign-extend ADJ

   // Bank select values after reset
   localparam logic [2:0] BLOCKD_RST = 3'd0;
   localparam logic [2:0] BLOCKE_RST = 3'd1;
   localparam logic [2:0] BLOCKF_RST = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_VALID = 2'd2
   } fetch_state_e;

   // Widen a 16-bit offset to 24 bits, sign- or zero-extended
   function automatic logic [23:0] ext16(input logic [15:0] v, input logic sgn);
      return sgn ? {{8{v[15]}}, v} : {8'h00, v};
   endfunction

endpackage

// File: rtl/spc7110_romfetch.sv
// Request/acknowledge ROM fetch engine with a one-byte data buffer.
// A start while a request is outstanding is remembered as pending; the
// outstanding ack is then swallowed and one fresh request goes out.
module spc7110_romfetch
   import spc7110_pkg::*;
#(
   parameter logic [23:0] DROM_BASE = 24'h100000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        start,
   input  logic [23:0] ea,
   input  logic        rom_ack,
   input  logic [7:0]  rom_data,
   output logic        rom_req,
   output logic [23:0] rom_addr,
   output logic [7:0]  buf_data,
   output logic        busy
);

   fetch_state_e state_q, state_d;
   logic        req_q, req_d;
   logic        pend_q, pend_d;
   logic [23:0] addr_q, addr_d;
   logic [7:0]  buf_q, buf_d;

   // State register; reset drops the request immediately
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         req_q   <= 1'b0;
         pend_q  <= 1'b0;
         addr_q  <= 24'h000000;
         buf_q   <= 8'h00;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         pend_q  <= pend_d;
         addr_q  <= addr_d;
         buf_q   <= buf_d;
      end
   end

   // Next-state logic; the address is only loaded while req is low so it
   // never moves under an outstanding request
   always_comb begin
      state_d = state_q;
      req_d   = req_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      buf_d   = buf_q;
      case (state_q)
         ST_FETCH: begin
            if (req_q) begin
               if (rom_ack) begin
                  req_d = 1'b0;
                  if (pend_q || start) begin
                     // stale data: drop it and re-request next cycle
                     pend_d = 1'b0;
                  end else begin
                     buf_d   = rom_data;
                     state_d = ST_VALID;
                  end
               end else if (start) begin
                  pend_d = 1'b1;
               end
            end else begin
               // re-issue after a discarded ack, at the current address
               req_d  = 1'b1;
               addr_d = DROM_BASE + ea;
            end
         end
         default: begin
            if (start) begin
               state_d = ST_FETCH;
               req_d   = 1'b1;
               addr_d  = DROM_BASE + ea;
            end
         end
      endcase
   end

   assign rom_req  = req_q;
   assign rom_addr = addr_q;
   assign buf_data = buf_q;
   assign busy     = (state_q == ST_FETCH) || pend_q;

endmodule

// File: rtl/spc7110_dataport.sv
// SPC7110 data ROM port: pointer/adjust/step/mode registers, bank selects,
// and the address arithmetic feeding the fetch engine.
module spc7110_dataport
   import spc7110_pkg::*;
#(
   parameter logic [23:0] DROM_BASE = 24'h100000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [3:0]  reg_addr,
   input  logic        direct_enable,
   input  logic        banked_enable,
   input  logic        reg_we,
   input  logic        reg_re,
   input  logic [7:0]  reg_wdata,
   output logic [7:0]  reg_rdata,
   output logic        rom_req,
   output logic [23:0] rom_addr,
   input  logic        rom_ack,
   input  logic [7:0]  rom_data,
   output logic        sram_enable,
   output logic [2:0]  blockd,
   output logic [2:0]  blocke,
   output logic [2:0]  blockf
);

   logic [23:0] dp_q, dp_d;
   logic [15:0] adj_q, adj_d;
   logic [15:0] stp_q, stp_d;
   logic [7:0]  mode_q, mode_d;
   logic        sram_q, sram_d;
   logic [2:0]  blockd_q, blockd_d, blocke_q, blocke_d, blockf_q, blockf_d;

   logic        wr_dir, wr_bank, rd_data, start;
   logic [23:0] ea;
   logic [7:0]  buf_data;
   logic        busy;

   assign wr_dir  = reg_we && direct_enable;
   assign wr_bank = reg_we && banked_enable;
   assign rd_data = reg_re && direct_enable && (reg_addr == DIR_DATA);
   assign start   = rd_data || (wr_dir && ((reg_addr == DIR_DP2) || (reg_addr == DIR_ADJ1)));

   // Register file
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         dp_q     <= 24'h000000;
         adj_q    <= 16'h0000;
         stp_q    <= 16'h0000;
         mode_q   <= 8'h00;
         sram_q   <= 1'b0;
         blockd_q <= BLOCKD_RST;
         blocke_q <= BLOCKE_RST;
         blockf_q <= BLOCKF_RST;
      end else begin
         dp_q     <= dp_d;
         adj_q    <= adj_d;
         stp_q    <= stp_d;
         mode_q   <= mode_d;
         sram_q   <= sram_d;
         blockd_q <= blockd_d;
         blocke_q <= blocke_d;
         blockf_q <= blockf_d;
      end
   end

   // Register writes and the post-read pointer advance
   always_comb begin
      dp_d     = dp_q;
      adj_d    = adj_q;
      stp_d    = stp_q;
      mode_d   = mode_q;
      sram_d   = sram_q;
      blockd_d = blockd_q;
      blocke_d = blocke_q;
      blockf_d = blockf_q;
      if (rd_data) begin
         dp_d = dp_q + (mode_q[MODE_STEP_EN] ? ext16(stp_q, mode_q[MODE_STEP_SIGNED]) : 24'h000001);
      end
      if (wr_dir) begin
         case (reg_addr)
            DIR_DP0:  dp_d[7:0]   = reg_wdata;
            DIR_DP1:  dp_d[15:8]  = reg_wdata;
            DIR_DP2:  dp_d[23:16] = reg_wdata;
            DIR_ADJ0: adj_d[7:0]  = reg_wdata;
            DIR_ADJ1: adj_d[15:8] = reg_wdata;
            DIR_STP0: stp_d[7:0]  = reg_wdata;
            DIR_STP1: stp_d[15:8] = reg_wdata;
            DIR_MODE: mode_d      = reg_wdata;
            default:  ;
         endcase
      end
      if (wr_bank) begin
         case (reg_addr)
            BANK_SRAM: sram_d   = reg_wdata[7];
            BANK_D:    blockd_d = reg_wdata[2:0];
            BANK_E:    blocke_d = reg_wdata[2:0];
            BANK_F:    blockf_d = reg_wdata[2:0];
            default:   ;
         endcase
      end
   end

   // Fetch address from next-cycle register values, so a start sees the
   // write or pointer advance that triggered it
   assign ea = dp_d + (mode_d[MODE_ADJ_EN] ? ext16(adj_d, mode_d[MODE_ADJ_SIGNED]) : 24'h000000);

   spc7110_romfetch #(.DROM_BASE(DROM_BASE)) u_fetch (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .start    (start),
      .ea       (ea),
      .rom_ack  (rom_ack),
      .rom_data (rom_data),
      .rom_req  (rom_req),
      .rom_addr (rom_addr),
      .buf_data (buf_data),
      .busy     (busy)
   );

   // Read-back mux; undefined offsets read zero
   always_comb begin
      reg_rdata = 8'h00;
      if (direct_enable) begin
         case (reg_addr)
            DIR_DATA:   reg_rdata = buf_data;
            DIR_DP0:    reg_rdata = dp_q[7:0];
            DIR_DP1:    reg_rdata = dp_q[15:8];
            DIR_DP2:    reg_rdata = dp_q[23:16];
            DIR_ADJ0:   reg_rdata = adj_q[7:0];
            DIR_ADJ1:   reg_rdata = adj_q[15:8];
            DIR_STP0:   reg_rdata = stp_q[7:0];
            DIR_STP1:   reg_rdata = stp_q[15:8];
            DIR_MODE:   reg_rdata = mode_q;
            DIR_STATUS: reg_rdata = {busy, 7'b0000000};
            default:    reg_rdata = 8'h00;
         endcase
      end else if (banked_enable) begin
         case (reg_addr)
            BANK_SRAM: reg_rdata = {sram_q, 7'b0000000};
            BANK_D:    reg_rdata = {5'b00000, blockd_q};
            BANK_E:    reg_rdata = {5'b00000, blocke_q};
            BANK_F:    reg_rdata = {5'b00000, blockf_q};
            default:   reg_rdata = 8'h00;
         endcase
      end
   end

   assign sram_enable = sram_q;
   assign blockd      = blockd_q;
   assign blocke      = blocke_q;
   assign blockf      = blockf_q;

endmodule
